// File: rtl/exception_ctrl.sv
// Exception/interrupt controller. It takes undefined-instruction exceptions and
// edge-triggered interrupts at the ID stage, runs a single-level handler and locks up on a nested exception.
module exception_ctrl #(
    parameter logic [31:0] INT_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic        exc_req,
    input  logic        eret,
    input  logic        pipe_stall,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] pc_int,
    output logic        pc_int_write,
    output logic [31:0] pc_int_data,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        kmode,
    output logic [1:0]  cause,
    output logic        halt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        RETURN  = 2'd2,
        LOCK    = 2'd3
    } state_t;

    state_t state, next_state;
    logic   irq_q, irq_pend;
    logic   id_go, take_exc, take_int, do_eret, do_lock;

    // Handshake: a take or nested-exception event fires only when ID holds a
    // real instruction (id_valid) that is leaving this cycle (~pipe_stall);
    // otherwise the request is simply retained.
    assign id_go    = id_valid & ~pipe_stall;
    assign take_exc = (state == IDLE) & id_go & exc_req;
    assign take_int = (state == IDLE) & id_go & ~exc_req & irq_pend;
    assign do_eret  = (state == HANDLER) & eret & ~pipe_stall;
    assign do_lock  = (state == HANDLER) & ~do_eret & exc_req & id_go;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            irq_q    <= 1'b0;
            irq_pend <= 1'b0;
            kmode    <= 1'b0;
            cause    <= 2'b00;
            halt     <= 1'b0;
        end else begin
            state    <= next_state;
            irq_q    <= irq;
            // A new edge in the take cycle must not be lost.
            irq_pend <= (irq & ~irq_q) | (irq_pend & ~take_int);
            kmode    <= (next_state == HANDLER) || (next_state == LOCK);
            halt     <= (next_state == LOCK);
            if (take_exc)
                cause <= 2'b10;
            else if (take_int)
                cause <= 2'b01;
            else if (do_eret)
                cause <= 2'b00;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take_exc || take_int) next_state = HANDLER;
            HANDLER: if (do_eret) next_state = RETURN;
                     else if (do_lock) next_state = LOCK;
            RETURN:  next_state = IDLE;
            LOCK:    next_state = LOCK;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pc_int_write = 1'b0;
        pc_int_data  = 32'd0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (take_exc) begin
                        pc_int_write = 1'b1;
                        pc_int_data  = id_pc + 32'd4;
                        redirect     = 1'b1;
                        redirect_pc  = EXC_VECTOR;
                        flush_if     = 1'b1;
                        flush_id     = 1'b1;
                    end else if (take_int) begin
                        pc_int_write = 1'b1;
                        pc_int_data  = id_pc;
                        redirect     = 1'b1;
                        redirect_pc  = INT_VECTOR;
                        flush_if     = 1'b1;
                        flush_id     = 1'b1;
                    end
                end
                HANDLER: begin
                    if (do_eret) begin
                        redirect    = 1'b1;
                        redirect_pc = pc_int;
                        flush_if    = 1'b1;
                    end
                end
                LOCK:    flush_if = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: a cycle-by-cycle vector trace plus
// hand-written stall, lock/reset and PC-wrap sequences.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq, exc_req, eret, pipe_stall, id_valid;
    logic [31:0] id_pc, pc_int;
    logic        pc_int_write, redirect, flush_if, flush_id, kmode, halt;
    logic [31:0] pc_int_data, redirect_pc;
    logic [1:0]  cause, state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .exc_req(exc_req), .eret(eret),
        .pipe_stall(pipe_stall), .id_valid(id_valid), .id_pc(id_pc), .pc_int(pc_int),
        .pc_int_write(pc_int_write), .pc_int_data(pc_int_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
        .kmode(kmode), .cause(cause), .halt(halt), .state_dbg(state_dbg)
    );

    typedef struct {
        logic        irq, exc_req, eret, pipe_stall, id_valid;
        logic [31:0] id_pc, pc_int;
        logic        e_piw;
        logic [31:0] e_pid;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_fif, e_fid, e_kmode;
        logic [1:0]  e_cause;
        logic        e_halt;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(int irq_i, int exc_i, int eret_i, int stall_i, int valid_i,
                                logic [31:0] pc_i, logic [31:0] pint_i,
                                int piw, logic [31:0] pid, int red, logic [31:0] rpc,
                                int fif, int fid, int km, int ca, int ha, int st);
        vec_t v;
        v.irq = irq_i[0]; v.exc_req = exc_i[0]; v.eret = eret_i[0];
        v.pipe_stall = stall_i[0]; v.id_valid = valid_i[0];
        v.id_pc = pc_i; v.pc_int = pint_i;
        v.e_piw = piw[0]; v.e_pid = pid; v.e_red = red[0]; v.e_rpc = rpc;
        v.e_fif = fif[0]; v.e_fid = fid[0]; v.e_kmode = km[0];
        v.e_cause = ca[1:0]; v.e_halt = ha[0]; v.e_state = st[1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i_irq, input logic i_exc, input logic i_eret,
                         input logic i_stall, input logic i_valid,
                         input logic [31:0] i_pc, input logic [31:0] i_pint);
        irq = i_irq; exc_req = i_exc; eret = i_eret; pipe_stall = i_stall;
        id_valid = i_valid; id_pc = i_pc; pc_int = i_pint;
    endtask

    // Sample mid-cycle, then move to just after the next rising edge.
    task automatic to_sample;
        @(negedge clk);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".piw"}, 32'(pc_int_write), 32'd0);
        chk({tag, ".red"}, 32'(redirect), 32'd0);
        chk({tag, ".fif"}, 32'(flush_if), 32'd0);
        chk({tag, ".fid"}, 32'(flush_id), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        //             irq exc eret stl val id_pc         pc_int   piw pid          red rpc          fif fid km ca ha st
        vecs[0]  = mk(0, 0, 0, 0, 1, 32'h10,       32'h0,   0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 1, 32'h20,       32'h0,   0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 1, 32'h40,       32'h0,   1, 32'h40,      1, 32'h80000004, 1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 1, 32'h80000004, 32'h40,  0, 32'h0,       0, 32'h0,       0, 0, 1, 1, 0, 1);
        vecs[4]  = mk(0, 0, 1, 0, 1, 32'h80000008, 32'h40,  0, 32'h0,       1, 32'h40,      1, 0, 1, 1, 0, 1);
        vecs[5]  = mk(0, 0, 1, 0, 1, 32'h44,       32'h40,  0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 2);
        vecs[6]  = mk(0, 0, 1, 0, 1, 32'h48,       32'h40,  0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 32'h4c,       32'h40,  0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 1, 32'h100,      32'h40,  1, 32'h104,     1, 32'h80000008, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h104, 0, 32'h0,       0, 32'h0,       0, 0, 1, 2, 0, 1);
        vecs[10] = mk(0, 0, 1, 1, 1, 32'h80000008, 32'h104, 0, 32'h0,       0, 32'h0,       0, 0, 1, 2, 0, 1);
        vecs[11] = mk(0, 0, 1, 0, 1, 32'h80000008, 32'h104, 0, 32'h0,       1, 32'h104,     1, 0, 1, 2, 0, 1);
        vecs[12] = mk(0, 0, 0, 0, 1, 32'h104,      32'h104, 0, 32'h0,       0, 32'h0,       0, 0, 0, 0, 0, 2);
        vecs[13] = mk(0, 0, 0, 0, 1, 32'h104,      32'h104, 1, 32'h104,     1, 32'h80000004, 1, 1, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,        32'h104, 0, 32'h0,       0, 32'h0,       0, 0, 1, 1, 0, 1);

        // Reset state, including combinational outputs held low during rst.
        rst = 1'b1;
        drive(1, 1, 0, 0, 1, 32'h40, 32'h40);
        next_cycle();
        to_sample();
        chk_quiet("rst");
        chk("rst.pid", pc_int_data, 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        chk("rst.kmode", 32'(kmode), 32'd0);
        chk("rst.cause", 32'(cause), 32'd0);
        chk("rst.halt", 32'(halt), 32'd0);
        chk("rst.state", 32'(state_dbg), 32'd0);
        next_cycle();
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].irq, vecs[i].exc_req, vecs[i].eret, vecs[i].pipe_stall,
                  vecs[i].id_valid, vecs[i].id_pc, vecs[i].pc_int);
            to_sample();
            chk($sformatf("v%0d.piw", i), 32'(pc_int_write), 32'(vecs[i].e_piw));
            chk($sformatf("v%0d.pid", i), pc_int_data, vecs[i].e_pid);
            chk($sformatf("v%0d.red", i), 32'(redirect), 32'(vecs[i].e_red));
            chk($sformatf("v%0d.rpc", i), redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d.fif", i), 32'(flush_if), 32'(vecs[i].e_fif));
            chk($sformatf("v%0d.fid", i), 32'(flush_id), 32'(vecs[i].e_fid));
            chk($sformatf("v%0d.kmode", i), 32'(kmode), 32'(vecs[i].e_kmode));
            chk($sformatf("v%0d.cause", i), 32'(cause), 32'(vecs[i].e_cause));
            chk($sformatf("v%0d.halt", i), 32'(halt), 32'(vecs[i].e_halt));
            chk($sformatf("v%0d.state", i), 32'(state_dbg), 32'(vecs[i].e_state));
            next_cycle();
        end

        // Interrupt edge during a 3-cycle stall: deferred, then taken with the current id_pc.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 1, 1, 32'h200 + 32'(c * 4), 32'h0);
            to_sample();
            chk($sformatf("stall%0d", c), 32'(pc_int_write | redirect | flush_if | flush_id), 32'd0);
            next_cycle();
        end
        drive(1, 0, 0, 0, 1, 32'h210, 32'h0);
        to_sample();
        chk("stall.take.piw", 32'(pc_int_write), 32'd1);
        chk("stall.take.pid", pc_int_data, 32'h210);
        chk("stall.take.rpc", redirect_pc, 32'h80000004);
        next_cycle();

        // Nested exception in HANDLER locks up until reset.
        drive(1, 1, 0, 0, 1, 32'h80000004, 32'h210);
        to_sample();
        chk("nest.kmode", 32'(kmode), 32'd1);
        chk_quiet("nest");
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive(c == 1, 0, 1, 0, 1, 32'h80000008, 32'h210);
            to_sample();
            chk($sformatf("lock%0d.halt", c), 32'(halt), 32'd1);
            chk($sformatf("lock%0d.kmode", c), 32'(kmode), 32'd1);
            chk($sformatf("lock%0d.fif", c), 32'(flush_if), 32'd1);
            chk($sformatf("lock%0d.red", c), 32'(redirect), 32'd0);
            chk($sformatf("lock%0d.state", c), 32'(state_dbg), 32'd3);
            next_cycle();
        end
        // An irq edge was just latched into irq_pend; reset must discard it.
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h300, 32'h210);
        to_sample();
        chk_quiet("lockrst.comb");
        next_cycle();
        rst = 1'b0;
        to_sample();
        chk("lockrst.halt", 32'(halt), 32'd0);
        chk("lockrst.kmode", 32'(kmode), 32'd0);
        chk("lockrst.cause", 32'(cause), 32'd0);
        chk("lockrst.state", 32'(state_dbg), 32'd0);
        chk_quiet("lockrst.nopend");
        next_cycle();

        // PC wrap on exception return address.
        drive(0, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h0);
        to_sample();
        chk("wrap.piw", 32'(pc_int_write), 32'd1);
        chk("wrap.pid", pc_int_data, 32'h00000000);
        chk("wrap.rpc", redirect_pc, 32'h80000008);
        next_cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        to_sample();
        chk("wrap.cause", 32'(cause), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
